// File: rtl/bird_motion.sv
// Bird vertical motion: integrates velocity and height under gravity on each frame tick
// and runs the IDLE/FLY/DEAD game-state machine.
module bird_motion #(
    parameter int YW      = 9,
    parameter int VW      = 6,
    parameter int Y_START = 200,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 440,
    parameter int GRAVITY = 1,
    parameter int FLAP_V  = 8,
    parameter int V_TERM  = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick_i,
    input  logic                 flap_i,
    input  logic                 hit_i,
    input  logic                 restart_i,
    output logic [YW-1:0]        bird_y_o,
    output logic signed [VW-1:0] vel_o,
    output logic [1:0]           state_o,
    output logic                 alive_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FLY  = 2'b01,
        ST_DEAD = 2'b10
    } state_e;

    // Height arithmetic is done two bits wider than YW so that both a negative
    // overshoot past the ceiling and an overshoot past the ground are visible.
    localparam int SW = YW + 2;

    localparam logic [YW-1:0]        Y_START_V = YW'(Y_START);
    localparam logic [YW-1:0]        Y_FLAP_V  = YW'(Y_START - FLAP_V);
    localparam logic [YW-1:0]        Y_MIN_V   = YW'(Y_MIN);
    localparam logic [YW-1:0]        Y_MAX_V   = YW'(Y_MAX);
    localparam logic signed [SW-1:0] Y_MIN_S   = SW'(Y_MIN);
    localparam logic signed [SW-1:0] Y_MAX_S   = SW'(Y_MAX);
    localparam logic signed [VW-1:0] FLAP_VEL  = VW'(-FLAP_V);
    localparam logic signed [VW-1:0] V_TERM_V  = VW'(V_TERM);
    localparam logic signed [VW:0]   V_TERM_X  = (VW+1)'(V_TERM);
    localparam logic signed [VW:0]   GRAV_X    = (VW+1)'(GRAVITY);

    state_e               state_q, state_d;
    logic [YW-1:0]        y_q, y_d;
    logic signed [VW-1:0] vel_q, vel_d;
    logic                 flap_pend_q, flap_pend_d;
    logic                 done_q, done_d;

    logic                 flap_eff;
    logic signed [VW:0]   v_inc;
    logic signed [VW-1:0] v_new;
    logic signed [SW-1:0] y_sum;

    // A flap arriving in the same cycle as a tick counts for that tick.
    assign flap_eff = flap_pend_q | flap_i;

    always_comb begin
        v_inc = $signed({vel_q[VW-1], vel_q}) + GRAV_X;
        if (flap_eff) begin
            v_new = FLAP_VEL;
        end else if (v_inc > V_TERM_X) begin
            v_new = V_TERM_V;
        end else begin
            v_new = v_inc[VW-1:0];
        end
        y_sum = $signed({2'b00, y_q}) + $signed({{(SW-VW){v_new[VW-1]}}, v_new});
    end

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        vel_d       = vel_q;
        flap_pend_d = flap_eff;
        done_d      = 1'b0;

        if (restart_i) begin
            state_d     = ST_IDLE;
            y_d         = Y_START_V;
            vel_d       = '0;
            flap_pend_d = 1'b0;
        end else begin
            done_d = tick_i;
            if (tick_i) begin
                flap_pend_d = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tick_i && flap_eff) begin
                        state_d = ST_FLY;
                        y_d     = Y_FLAP_V;
                        vel_d   = FLAP_VEL;
                    end
                end
                ST_FLY: begin
                    if (hit_i) begin
                        state_d = ST_DEAD;
                        vel_d   = '0;
                    end else if (tick_i) begin
                        if (y_sum < Y_MIN_S) begin
                            y_d   = Y_MIN_V;
                            vel_d = '0;
                        end else if (y_sum >= Y_MAX_S) begin
                            state_d = ST_DEAD;
                            y_d     = Y_MAX_V;
                            vel_d   = '0;
                        end else begin
                            y_d   = y_sum[YW-1:0];
                            vel_d = v_new;
                        end
                    end
                end
                ST_DEAD: begin
                end
                default: begin
                    state_d = ST_IDLE;
                    y_d     = Y_START_V;
                    vel_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            y_q         <= Y_START_V;
            vel_q       <= '0;
            flap_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            flap_pend_q <= flap_pend_d;
            done_q      <= done_d;
        end
    end

    assign bird_y_o = y_q;
    assign vel_o    = vel_q;
    assign state_o  = state_q;
    assign alive_o  = (state_q != ST_DEAD);
    assign done_o   = done_q;

endmodule
